// File: rtl/alu_instr_sequencer.sv
// Hardwired control-step sequencer for instruction fetch and three-register ALU instructions.
// Walks T0..T6 from IR contents, handshakes with the ALU via start/finished and writes the
// result to Ra, or to LO then HI for multiply/divide.
// Optional build macro SINGLE_STEP_EN adds a step_req input: a new instruction starts only when
// run and step_req are both high in IDLE.
module alu_instr_sequencer #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter logic [4:0]  MUL_OPC    = 5'h0E,
  parameter logic [4:0]  DIV_OPC    = 5'h0F
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step_req,
`endif
  input  logic [31:0] IR,
  input  logic        finished,
  output logic        PCout,
  output logic        RZLOout,
  output logic        RZHIout,
  output logic        MDRout,
  output logic        RFout,
  output logic        PCin,
  output logic        MARin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        IRin,
  output logic        RYin,
  output logic        RZin,
  output logic        RFin,
  output logic        RHIin,
  output logic        RLOin,
  output logic [3:0]  RFSelect,
  output logic [5:0]  opSelect,
  output logic        start,
  output logic [2:0]  step,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);

  // Encodings double as the externally visible step number.
  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StT5   = 3'd5,
    StT6   = 3'd6,
    StIdle = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic [5:0] dec_op;
  logic       dec_illegal;
  logic       is_muldiv;
  logic       timed_out;
  logic       launch;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign is_muldiv = (opc == MUL_OPC) || (opc == DIV_OPC);
  // After WAIT_LIMIT T4 cycles without finished, one more T4 cycle flags the abort.
  assign timed_out = (wait_cnt_q == CntW'(WAIT_LIMIT));
  assign step      = state_q;

`ifdef SINGLE_STEP_EN
  assign launch = run & step_req;
`else
  assign launch = run;
`endif

  // State and T4 wait counter; clear has priority over everything else.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Opcode decode to ALU operation select.
  always_comb begin
    dec_illegal = 1'b0;
    dec_op      = {1'b0, opc};
    case (opc)
      5'h08: dec_op = 6'h1B;
      5'h09: dec_op = 6'h1C;
      5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
      5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F: ;
      default: begin
        dec_illegal = 1'b1;
        dec_op      = '0;
      end
    endcase
  end

  // Counts elapsed T4 cycles; zero everywhere else so each instruction starts fresh.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == StT4 && !timed_out) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Next-state and control outputs; all Moore except RZin while waiting in T4.
  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    RZLOout  = 1'b0;
    RZHIout  = 1'b0;
    MDRout   = 1'b0;
    RFout    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    RYin     = 1'b0;
    RZin     = 1'b0;
    RFin     = 1'b0;
    RHIin    = 1'b0;
    RLOin    = 1'b0;
    RFSelect = '0;
    opSelect = '0;
    start    = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      StIdle: begin
        if (launch) state_d = StT0;
      end
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        RZin    = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        RZLOout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = StIdle;
        end else begin
          opSelect = dec_op;
          RFSelect = rb;
          RFout    = 1'b1;
          RYin     = 1'b1;
          state_d  = StT4;
        end
      end
      StT4: begin
        opSelect = dec_op;
        RFSelect = rc;
        RFout    = 1'b1;
        if (timed_out) begin
          illegal = 1'b1;
          state_d = StIdle;
        end else begin
          start = (wait_cnt_q == '0);
          // A result arriving together with clear is dropped.
          RZin  = finished & ~clear;
          if (finished) state_d = StT5;
        end
      end
      StT5: begin
        opSelect = dec_op;
        RZLOout  = 1'b1;
        if (is_muldiv) begin
          RLOin   = 1'b1;
          state_d = StT6;
        end else begin
          RFSelect = ra;
          RFin     = 1'b1;
          done     = 1'b1;
          state_d  = StIdle;
        end
      end
      StT6: begin
        opSelect = dec_op;
        RZHIout  = 1'b1;
        RHIin    = 1'b1;
        done     = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: a reference model pushes the expected per-instruction
// profile when an instruction is launched; a monitor accumulates what the DUT did and compares
// when done or illegal pulses.
module tb_alu_instr_sequencer;

  logic        Clock = 1'b0;
  logic        clear, run;
  logic        finished = 1'b0;
  logic [31:0] IR;
  logic        PCout, RZLOout, RZHIout, MDRout, RFout;
  logic        PCin, MARin, IncPC, Read, MDRin, IRin, RYin, RZin, RFin, RHIin, RLOin;
  logic [3:0]  RFSelect;
  logic [5:0]  opSelect;
  logic        start, done, illegal;
  logic [2:0]  step;
  logic [28:0] all_out;

  assign all_out = {PCout, RZLOout, RZHIout, MDRout, RFout, PCin, MARin, IncPC, Read, MDRin,
                    IRin, RYin, RZin, RFin, RHIin, RLOin, RFSelect, opSelect, start, done,
                    illegal};

  alu_instr_sequencer dut (
    .Clock    (Clock),
    .clear    (clear),
    .run      (run),
    .IR       (IR),
    .finished (finished),
    .PCout    (PCout),
    .RZLOout  (RZLOout),
    .RZHIout  (RZHIout),
    .MDRout   (MDRout),
    .RFout    (RFout),
    .PCin     (PCin),
    .MARin    (MARin),
    .IncPC    (IncPC),
    .Read     (Read),
    .MDRin    (MDRin),
    .IRin     (IRin),
    .RYin     (RYin),
    .RZin     (RZin),
    .RFin     (RFin),
    .RHIin    (RHIin),
    .RLOin    (RLOin),
    .RFSelect (RFSelect),
    .opSelect (opSelect),
    .start    (start),
    .step     (step),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int kind;    // 0 done, 1 illegal
    int cycles;  // non-IDLE cycles from T0 to the ending pulse
    int t4;
    int start;
    int ryin;
    int rzin;
    int rfin;
    int rlo;
    int rhi;
    int opsel;
    int rb;
    int rc;
    int ra;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   exp_done  = 0;
  int   obs_done  = 0;
  int   fin_delay = 0;
  bit   fin_tie   = 1'b0;
  int   t4k       = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference model of one instruction given IR and the T4 cycle on which finished rises
  // (0 or beyond 16 means it never rises).
  function automatic rec_t model(input logic [31:0] ir, input int d);
    rec_t       r;
    logic [4:0] opc;
    bit         legal;
    r     = '{default: 0};
    opc   = ir[31:27];
    legal = 1'b1;
    if (opc == 5'h08) r.opsel = 'h1B;
    else if (opc == 5'h09) r.opsel = 'h1C;
    else if ((opc >= 5'h03 && opc <= 5'h07) || (opc >= 5'h0A && opc <= 5'h0F)) r.opsel = int'(opc);
    else legal = 1'b0;
    r.rzin = 1;
    if (!legal) begin
      r.kind   = 1;
      r.cycles = 4;
      return r;
    end
    r.ryin  = 1;
    r.start = 1;
    r.rb    = int'(ir[22:19]);
    r.rc    = int'(ir[18:15]);
    if (d < 1 || d > 16) begin
      r.kind   = 1;
      r.t4     = 17;
      r.cycles = 21;
      return r;
    end
    r.t4   = d;
    r.rzin = 2;
    if (opc == 5'h0E || opc == 5'h0F) begin
      r.rlo    = 1;
      r.rhi    = 1;
      r.cycles = d + 6;
    end else begin
      r.rfin   = 1;
      r.ra     = int'(ir[26:23]);
      r.cycles = d + 5;
    end
    return r;
  endfunction

  // ALU stand-in: raises finished on the programmed T4 cycle.
  always @(negedge Clock) begin
    if (step == 3'd4) t4k = t4k + 1;
    else t4k = 0;
    finished = fin_tie || (step == 3'd4 && fin_delay != 0 && t4k == fin_delay);
  end

  // Monitor: per-cycle invariants plus per-instruction accumulation and scoreboard compare.
  always begin
    rec_t e;
    @(negedge Clock);
    #2;
    chk("bus_exclusive", 32'($countones({PCout, RZLOout, RZHIout, MDRout, RFout}) <= 1), 1);
    chk("done_illegal_excl", 32'(done & illegal), 0);
    if (step < 3'd3 || step > 3'd5) chk("rfsel_zero", RFSelect, 0);
    if (step >= 3'd4 && step <= 3'd6) chk("opsel_stable", opSelect, obs.opsel);
    if (step == 3'd0) obs = '{default: 0};
    if (step != 3'd7) begin
      obs.cycles += 1;
      if (step == 3'd3) obs.opsel = int'(opSelect);
      if (step == 3'd4) begin
        if (obs.t4 == 0) obs.rc = int'(RFSelect);
        obs.t4 += 1;
      end
      if (start) obs.start += 1;
      if (RYin) begin
        obs.ryin += 1;
        obs.rb = int'(RFSelect);
      end
      if (RZin) obs.rzin += 1;
      if (RFin) begin
        obs.rfin += 1;
        obs.ra = int'(RFSelect);
      end
      if (RLOin) obs.rlo += 1;
      if (RHIin) obs.rhi += 1;
    end
    if (done) obs_done++;
    if (done || illegal) begin
      obs.kind = illegal ? 1 : 0;
      chk("expectation_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("end_kind", obs.kind, e.kind);
        chk("cycles", obs.cycles, e.cycles);
        chk("t4_cycles", obs.t4, e.t4);
        chk("start_pulses", obs.start, e.start);
        chk("ryin_count", obs.ryin, e.ryin);
        chk("rzin_count", obs.rzin, e.rzin);
        chk("rfin_count", obs.rfin, e.rfin);
        chk("rloin_count", obs.rlo, e.rlo);
        chk("rhiin_count", obs.rhi, e.rhi);
        chk("opsel", obs.opsel, e.opsel);
        chk("rfsel_rb", obs.rb, e.rb);
        chk("rfsel_rc", obs.rc, e.rc);
        chk("rfsel_ra", obs.ra, e.ra);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (step == 3'd7) return;
      @(negedge Clock);
    end
    chk("idle_reached", step, 7);
  endtask

  task automatic push_exp(input logic [31:0] ir, input int d);
    rec_t r;
    r = model(ir, d);
    exp_q.push_back(r);
    if (r.kind == 0) exp_done++;
  endtask

  task automatic launch(input logic [31:0] ir, input int d, input bit push);
    wait_idle();
    IR        = ir;
    fin_delay = d;
    if (push) push_exp(ir, d);
    run = 1'b1;
    @(negedge Clock);
    run = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] ir;
    logic [4:0]  opc;
    clear = 1'b1;
    run   = 1'b0;
    IR    = '0;
    repeat (2) @(negedge Clock);
    clear = 1'b0;
    #1;
    chk("reset_step", step, 7);
    chk("reset_outputs", all_out, 0);
    @(negedge Clock);

    // ror with finished tied high
    fin_tie = 1'b1;
    launch(32'h4091_8000, 1, 1'b1);
    wait_idle();
    fin_tie = 1'b0;

    // mul Ra=4 Rb=5 Rc=6, finished on the 8th T4 cycle
    launch({5'h0E, 4'd4, 4'd5, 4'd6, 15'h0}, 8, 1'b1);
    // div and an ALU op writing R0
    launch({5'h0F, 4'd9, 4'd1, 4'd2, 15'h1234}, 3, 1'b1);
    launch({5'h03, 4'd0, 4'd7, 4'd8, 15'h0}, 2, 1'b1);
    launch({5'h09, 4'd15, 4'd14, 4'd13, 15'h7FFF}, 16, 1'b1);
    // timeout
    launch({5'h05, 4'd3, 4'd4, 4'd5, 15'h0}, 0, 1'b1);
    // illegal opcodes
    launch({5'h1F, 4'd1, 4'd2, 4'd3, 15'h0}, 1, 1'b1);
    launch({5'h02, 4'd1, 4'd2, 4'd3, 15'h0}, 1, 1'b1);

    // clear in T4 coinciding with finished
    launch({5'h0E, 4'd4, 4'd5, 4'd6, 15'h0}, 4, 1'b0);
    for (int i = 0; i < 20 && step != 3'd4; i++) @(negedge Clock);
    chk("reached_t4", step, 4);
    repeat (3) @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
    #1;
    chk("clear_step", step, 7);
    chk("clear_outputs", all_out, 0);
    repeat (3) @(negedge Clock);
    chk("clear_no_done", obs_done, exp_done);
    // timeout right after clear exercises the counter reset
    launch({5'h0A, 4'd2, 4'd3, 4'd4, 15'h0}, 0, 1'b1);

    // back-to-back with run held
    wait_idle();
    IR        = {5'h06, 4'd5, 4'd6, 4'd7, 15'h0};
    fin_delay = 2;
    push_exp(IR, 2);
    push_exp(IR, 2);
    run = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (done) break;
    end
    @(negedge Clock);
    chk("b2b_gap_idle", step, 7);
    @(negedge Clock);
    chk("b2b_restart", step, 0);
    run = 1'b0;
    wait_idle();
    repeat (3) @(negedge Clock);
    chk("stays_idle", step, 7);

    // random legal instructions
    for (int n = 0; n < 1000; n++) begin
      rnd = $urandom();
      opc = 5'($urandom_range(3, 15));
      ir  = {opc, rnd[26:0]};
      launch(ir, int'($urandom_range(0, 16)), 1'b1);
    end

    wait_idle();
    repeat (3) @(negedge Clock);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_count", obs_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
